aer_synapse_driver: RTL and testbench

//  Receiver for the AER spike bus. Turns address-events from a presynaptic population into
//  per-neuron synaptic currents for lif_neuron_array. Each event adds one row of a weight table
//  to NUM_POST current accumulators. On every step_tick the accumulators go out as

---
 rtl/aer_synapse_driver.sv | 244 ++++++++++++++++++++++++
 tb/tb_aer_synapse_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_synapse_driver.sv
// aer_synapse_driver
//   AER spike-bus receiver. Each accepted address-event adds one row of the
//   weight table into NUM_POST signed Q8.8 current accumulators, one column
//   per cycle. Each step_tick publishes the accumulators on synaptic_currents
//   with a one-cycle all-ones input_valid. The accumulators then either decay
//   or clear.
//   Optional feature macro: SYN_DECAY_EN
//     defined   -> exponential synapse, acc <= acc - (acc >>> DECAY_SHIFT)
//     undefined -> delta synapse, acc <= 0 after every emit
module aer_synapse_driver #(
    parameter int NUM_PRE     = 8,
    parameter int NUM_POST    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int DECAY_SHIFT = 3,
    localparam int ADDR_W     = (NUM_PRE  > 1) ? $clog2(NUM_PRE)  : 1,
    localparam int POST_W     = (NUM_POST > 1) ? $clog2(NUM_POST) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           ev_valid,
    input  logic [ADDR_W-1:0]              ev_addr,
    output logic                           ev_ready,
    input  logic                           step_tick,
    input  logic                           w_we,
    input  logic [ADDR_W-1:0]              w_pre,
    input  logic [POST_W-1:0]              w_post,
    input  logic [DATA_WIDTH-1:0]          w_data,
    output logic [NUM_POST*DATA_WIDTH-1:0] synaptic_currents,
    output logic [NUM_POST-1:0]            input_valid,
    output logic                           busy,
    output logic                           tick_overrun,
    output logic [7:0]                     bad_ev_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DECAY = 2'd3
    } state_e;

    // Clamp a DATA_WIDTH+1 signed result into the DATA_WIDTH signed range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_wide(input logic signed [DATA_WIDTH:0] s);
        logic signed [DATA_WIDTH-1:0] r;
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            if (s[DATA_WIDTH]) begin
                r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            r = s[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    // Saturating signed add.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(input logic signed [DATA_WIDTH-1:0] a,
                                                            input logic signed [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        return sat_wide(s);
    endfunction

    // Post-emit accumulator update: leak a fraction, or clear for a delta synapse.
    function automatic logic signed [DATA_WIDTH-1:0] decay_step(input logic signed [DATA_WIDTH-1:0] a);
        logic signed [DATA_WIDTH-1:0] r;
`ifdef SYN_DECAY_EN
        logic signed [DATA_WIDTH-1:0] sh;
        logic signed [DATA_WIDTH:0]   s;
        sh = a >>> DECAY_SHIFT;
        s  = {a[DATA_WIDTH-1], a} - {sh[DATA_WIDTH-1], sh};
        r  = sat_wide(s);
`else
        r  = a & {DATA_WIDTH{1'b0}};
`endif
        return r;
    endfunction

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [POST_W-1:0]               j_q, j_d;
    logic                            tick_pending_q, tick_pending_d;
    logic                            tick_overrun_q, tick_overrun_d;
    logic [7:0]                      bad_ev_cnt_q, bad_ev_cnt_d;
    logic [NUM_POST*DATA_WIDTH-1:0]  currents_q, currents_d;
    logic [NUM_POST-1:0]             input_valid_q, input_valid_d;
    logic signed [DATA_WIDTH-1:0]    acc_q [NUM_POST];
    logic signed [DATA_WIDTH-1:0]    acc_d [NUM_POST];
    logic signed [DATA_WIDTH-1:0]    w_q   [NUM_PRE][NUM_POST];
    logic                            addr_ok_s;

    assign ev_ready          = enable & (state_q == ST_IDLE) & ~tick_pending_q & ~step_tick;
    assign busy              = (state_q != ST_IDLE);
    assign synaptic_currents = currents_q;
    assign input_valid       = input_valid_q;
    assign tick_overrun      = tick_overrun_q;
    assign bad_ev_cnt        = bad_ev_cnt_q;

    // Decode whether the incoming event address names a real presynaptic source.
    always_comb begin
        addr_ok_s = 1'b0;
        for (int p = 0; p < NUM_PRE; p++) begin
            addr_ok_s = addr_ok_s | (ev_addr == ADDR_W'(p));
        end
    end

    // Next-state and datapath logic; enable=0 leaves every value at its current state.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        j_d            = j_q;
        tick_pending_d = tick_pending_q;
        tick_overrun_d = tick_overrun_q;
        bad_ev_cnt_d   = bad_ev_cnt_q;
        currents_d     = currents_q;
        input_valid_d  = input_valid_q;
        for (int i = 0; i < NUM_POST; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (enable) begin
            // A tick while one is still pending is merged, but flagged.
            if (step_tick && tick_pending_q) begin
                tick_overrun_d = 1'b1;
            end else begin
                tick_overrun_d = tick_overrun_q;
            end
            // Ticks outside IDLE are remembered until the FSM can emit.
            if (step_tick && (state_q != ST_IDLE)) begin
                tick_pending_d = 1'b1;
            end else begin
                tick_pending_d = tick_pending_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick_pending_q || step_tick) begin
                        tick_pending_d = 1'b0;
                        state_d        = ST_EMIT;
                    end else if (ev_valid) begin
                        if (addr_ok_s) begin
                            addr_d  = ev_addr;
                            j_d     = {POST_W{1'b0}};
                            state_d = ST_ACCUM;
                        end else if (bad_ev_cnt_q != 8'hFF) begin
                            bad_ev_cnt_d = bad_ev_cnt_q + 8'd1;
                        end else begin
                            bad_ev_cnt_d = bad_ev_cnt_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    acc_d[j_q] = sat_add(acc_q[j_q], w_q[addr_q][j_q]);
                    if (j_q == POST_W'(NUM_POST - 1)) begin
                        j_d     = {POST_W{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        j_d     = j_q + POST_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
                ST_EMIT: begin
                    for (int i = 0; i < NUM_POST; i++) begin
                        currents_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
                    end
                    input_valid_d = {NUM_POST{1'b1}};
                    state_d       = ST_DECAY;
                end
                ST_DECAY: begin
                    for (int i = 0; i < NUM_POST; i++) begin
                        acc_d[i] = decay_step(acc_q[i]);
                    end
                    input_valid_d = {NUM_POST{1'b0}};
                    state_d       = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= {ADDR_W{1'b0}};
            j_q            <= {POST_W{1'b0}};
            tick_pending_q <= 1'b0;
            tick_overrun_q <= 1'b0;
            bad_ev_cnt_q   <= 8'd0;
            currents_q     <= {(NUM_POST*DATA_WIDTH){1'b0}};
            input_valid_q  <= {NUM_POST{1'b0}};
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            j_q            <= j_d;
            tick_pending_q <= tick_pending_d;
            tick_overrun_q <= tick_overrun_d;
            bad_ev_cnt_q   <= bad_ev_cnt_d;
            currents_q     <= currents_d;
            input_valid_q  <= input_valid_d;
        end
    end

    // Current accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POST; i++) begin
                acc_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_POST; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Weight table: writable in any state; unmatched (out-of-range) indices write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PRE; p++) begin
                for (int q = 0; q < NUM_POST; q++) begin
                    w_q[p][q] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int p = 0; p < NUM_PRE; p++) begin
                for (int q = 0; q < NUM_POST; q++) begin
                    if (w_we && (w_pre == ADDR_W'(p)) && (w_post == POST_W'(q))) begin
                        w_q[p][q] <= w_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aer_synapse_driver.sv
// Directed testbench for aer_synapse_driver (NUM_PRE=6, DECAY_SHIFT=2).
module tb_aer_synapse_driver;

    localparam int NPRE  = 6;
    localparam int NPOST = 16;
    localparam int DW    = 16;
    localparam int DS    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  ev_valid;
    logic [2:0]            ev_addr;
    logic                  ev_ready;
    logic                  step_tick;
    logic                  w_we;
    logic [2:0]            w_pre;
    logic [3:0]            w_post;
    logic [DW-1:0]         w_data;
    logic [NPOST*DW-1:0]   synaptic_currents;
    logic [NPOST-1:0]      input_valid;
    logic                  busy;
    logic                  tick_overrun;
    logic [7:0]            bad_ev_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    aer_synapse_driver #(
        .NUM_PRE(NPRE), .NUM_POST(NPOST), .DATA_WIDTH(DW), .DECAY_SHIFT(DS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_ready(ev_ready),
        .step_tick(step_tick), .w_we(w_we), .w_pre(w_pre), .w_post(w_post), .w_data(w_data),
        .synaptic_currents(synaptic_currents), .input_valid(input_valid),
        .busy(busy), .tick_overrun(tick_overrun), .bad_ev_cnt(bad_ev_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ch(input int i);
        return synaptic_currents[i*DW +: DW];
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b1; ev_valid = 1'b0; ev_addr = 3'd0; step_tick = 1'b0;
        w_we = 1'b0; w_pre = 3'd0; w_post = 4'd0; w_data = 16'h0000;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic write_w(input logic [2:0] p, input logic [3:0] q, input logic [DW-1:0] d);
        w_we = 1'b1; w_pre = p; w_post = q; w_data = d;
        step();
        w_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ev_ready && n < 100) begin
            step();
            n++;
        end
        if (!ev_ready) begin
            n_checks++;
            $display("FAIL wait_ready: ev_ready=%0b after %0d cycles, expected 1", ev_ready, n);
        end
    endtask

    task automatic send_ev(input logic [2:0] a);
        wait_ready();
        ev_valid = 1'b1; ev_addr = a;
        step();
        ev_valid = 1'b0;
    endtask

    // Tick from IDLE; returns with the DUT in DECAY (input_valid high).
    task automatic emit_tick();
        wait_ready();
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL reset_ev_ready: got %0b expected 1", ev_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (synaptic_currents !== '0) $display("FAIL reset_currents: got %h expected 0", synaptic_currents); else n_pass++;
        n_checks++; if (input_valid !== 16'h0000) $display("FAIL reset_valid: got %h expected 0000", input_valid); else n_pass++;
        n_checks++; if (tick_overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", tick_overrun); else n_pass++;
        n_checks++; if (bad_ev_cnt !== 8'd0) $display("FAIL reset_bad_cnt: got %0d expected 0", bad_ev_cnt); else n_pass++;
    endtask

    task automatic test_accumulate();
        logic [NPOST*DW-1:0] exp_cur;
        int n;
        apply_reset();
        write_w(3'd2, 4'd0, 16'h0100);
        write_w(3'd2, 4'd1, 16'hFF00);
        send_ev(3'd2);
        n = 0;
        while (!ev_ready && n < 40) begin
            n++;
            step();
        end
        n_checks++; if (n != 16) $display("FAIL accum_ready_low: got %0d cycles expected 16", n); else n_pass++;
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
        n_checks++; if (input_valid !== 16'h0000) $display("FAIL accum_valid_early: got %h expected 0000", input_valid); else n_pass++;
        step();
        exp_cur = '0;
        exp_cur[15:0]  = 16'h0100;
        exp_cur[31:16] = 16'hFF00;
        n_checks++; if (input_valid !== 16'hFFFF) $display("FAIL accum_valid: got %h expected FFFF", input_valid); else n_pass++;
        n_checks++; if (synaptic_currents !== exp_cur) $display("FAIL accum_currents: got %h expected %h", synaptic_currents, exp_cur); else n_pass++;
        step();
        n_checks++; if (input_valid !== 16'h0000) $display("FAIL accum_valid_one_cycle: got %h expected 0000", input_valid); else n_pass++;
        n_checks++; if (synaptic_currents !== exp_cur) $display("FAIL accum_currents_hold: got %h expected %h", synaptic_currents, exp_cur); else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        write_w(3'd0, 4'd0, 16'h7000);
        send_ev(3'd0);
        send_ev(3'd0);
        emit_tick();
        n_checks++; if (ch(0) !== 16'h7FFF) $display("FAIL sat_pos: got %h expected 7FFF", ch(0)); else n_pass++;
        n_checks++; if (ch(1) !== 16'h0000) $display("FAIL sat_pos_ch1: got %h expected 0000", ch(1)); else n_pass++;
        apply_reset();
        write_w(3'd0, 4'd0, 16'h9000);
        send_ev(3'd0);
        send_ev(3'd0);
        emit_tick();
        n_checks++; if (ch(0) !== 16'h8000) $display("FAIL sat_neg: got %h expected 8000", ch(0)); else n_pass++;
    endtask

    task automatic test_tick_in_accum();
        int n;
        int pulses;
        apply_reset();
        write_w(3'd1, 4'd0, 16'h0050);
        send_ev(3'd1);
        step(); step(); step();
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
        n = 0;
        while (input_valid !== 16'hFFFF && n < 60) begin
            step();
            n++;
        end
        n_checks++; if (n != 14) $display("FAIL tick_accum_latency: got %0d cycles expected 14", n); else n_pass++;
        n_checks++; if (ch(0) !== 16'h0050) $display("FAIL tick_accum_value: got %h expected 0050", ch(0)); else n_pass++;
        n_checks++; if (tick_overrun !== 1'b0) $display("FAIL tick_accum_overrun: got %0b expected 0", tick_overrun); else n_pass++;

        apply_reset();
        write_w(3'd1, 4'd0, 16'h0050);
        send_ev(3'd1);
        step();
        step_tick = 1'b1; step(); step_tick = 1'b0;
        step();
        step_tick = 1'b1; step(); step_tick = 1'b0;
        n_checks++; if (tick_overrun !== 1'b1) $display("FAIL overrun_set: got %0b expected 1", tick_overrun); else n_pass++;
        n = 0;
        while (input_valid !== 16'hFFFF && n < 60) begin
            step();
            n++;
        end
        n_checks++; if (ch(0) !== 16'h0050) $display("FAIL overrun_value: got %h expected 0050", ch(0)); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (input_valid !== 16'h0000) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL overrun_single_emit: got %0d extra valid cycles expected 0", pulses); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL overrun_idle: got busy=%0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_decay();
        logic [DW-1:0] exp2;
`ifdef SYN_DECAY_EN
        exp2 = 16'h0300;
`else
        exp2 = 16'h0000;
`endif
        apply_reset();
        write_w(3'd3, 4'd0, 16'h0400);
        send_ev(3'd3);
        emit_tick();
        n_checks++; if (ch(0) !== 16'h0400) $display("FAIL decay_first: got %h expected 0400", ch(0)); else n_pass++;
        emit_tick();
        n_checks++; if (ch(0) !== exp2) $display("FAIL decay_second: got %h expected %h", ch(0), exp2); else n_pass++;
    endtask

    task automatic test_invalid_and_enable();
        apply_reset();
        ev_valid = 1'b1; ev_addr = 3'd7;
        #1;
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL bad_ev_ready: got %0b expected 1", ev_ready); else n_pass++;
        step();
        ev_valid = 1'b0;
        n_checks++; if (bad_ev_cnt !== 8'd1) $display("FAIL bad_ev_cnt1: got %0d expected 1", bad_ev_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0 || ev_ready !== 1'b1) $display("FAIL bad_ev_idle: got busy=%0b ready=%0b expected 0/1", busy, ev_ready); else n_pass++;
        send_ev(3'd6);
        n_checks++; if (bad_ev_cnt !== 8'd2) $display("FAIL bad_ev_cnt2: got %0d expected 2", bad_ev_cnt); else n_pass++;
        emit_tick();
        n_checks++; if (synaptic_currents !== '0) $display("FAIL bad_ev_acc: got %h expected 0", synaptic_currents); else n_pass++;
        wait_ready();
        enable = 1'b0; ev_valid = 1'b1; ev_addr = 3'd5;
        #1;
        n_checks++; if (ev_ready !== 1'b0) $display("FAIL disabled_ready: got %0b expected 0", ev_ready); else n_pass++;
        step(); step();
        write_w(3'd5, 4'd0, 16'h0123);
        step_tick = 1'b1; step(); step_tick = 1'b0;
        ev_valid = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0 || input_valid !== 16'h0000) $display("FAIL disabled_hold: got busy=%0b valid=%h expected 0/0000", busy, input_valid); else n_pass++;
        enable = 1'b1;
        step();
        n_checks++; if (input_valid !== 16'h0000 || busy !== 1'b0) $display("FAIL disabled_tick_ignored: got busy=%0b valid=%h expected 0/0000", busy, input_valid); else n_pass++;
        send_ev(3'd5);
        emit_tick();
        n_checks++; if (ch(0) !== 16'h0123) $display("FAIL disabled_write: got %h expected 0123", ch(0)); else n_pass++;
        n_checks++; if (bad_ev_cnt !== 8'd2) $display("FAIL disabled_bad_cnt: got %0d expected 2", bad_ev_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_accum();
        apply_reset();
        write_w(3'd2, 4'd0, 16'h0100);
        send_ev(3'd2);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0 || ev_ready !== 1'b1) $display("FAIL midreset_idle: got busy=%0b ready=%0b expected 0/1", busy, ev_ready); else n_pass++;
        emit_tick();
        n_checks++; if (synaptic_currents !== '0) $display("FAIL midreset_acc: got %h expected 0", synaptic_currents); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_saturation();
        test_tick_in_accum();
        test_decay();
        test_invalid_and_enable();
        test_reset_mid_accum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
